// File: rtl/turbo_pkg.sv
// turbo_pkg: shared constants for the turbo interleaver read/write length logic.
//   - PB size codes as carried on pb_size
//   - block lengths L for each physical block size
//   - length/address width
//   - read-side FSM state encoding
package turbo_pkg;

    localparam int LEN_W = 12;

    typedef enum logic [1:0] {
        PB16    = 2'b00,
        PB136   = 2'b01,
        PB520   = 2'b10,
        PB_RSVD = 2'b11
    } pb_size_e;

    localparam logic [LEN_W-1:0] L_PB16  = 12'd64;
    localparam logic [LEN_W-1:0] L_PB136 = 12'd544;
    localparam logic [LEN_W-1:0] L_PB520 = 12'd2080;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_READ = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/pb_len_dec.sv
// pb_len_dec: combinational PB size -> block length decode.
//   i_size : 2-bit PB size code
//   o_len  : symbols in the block (0 for the reserved code)
//   o_vld  : 1 when i_size is a legal size
module pb_len_dec
    import turbo_pkg::*;
(
    input  logic [1:0]       i_size,
    output logic [LEN_W-1:0] o_len,
    output logic             o_vld
);

    always_comb begin
        o_len = '0;
        o_vld = 1'b0;
        case (pb_size_e'(i_size))
            PB16:    begin o_len = L_PB16;  o_vld = 1'b1; end
            PB136:   begin o_len = L_PB136; o_vld = 1'b1; end
            PB520:   begin o_len = L_PB520; o_vld = 1'b1; end
            default: begin o_len = '0;      o_vld = 1'b0; end
        endcase
    end

endmodule

// File: rtl/turbo_rd_len.sv
// turbo_rd_len: read-side length/address controller for the ping-pong
// turbo interleaver RAM. Drains one bank per block, then swaps banks.
//   i_clk, i_n_rst : clock, async active-low reset
//   i_start        : writer pulse, a bank is full
//   i_pb_size      : PB size code, sampled with i_start
//   i_rd_rdy       : downstream can take a symbol next cycle
//   o_rd_en        : RAM read strobe
//   o_rd_addr      : symbol index within the bank
//   o_rd_bank      : bank being read
//   o_pb_len       : length of the block in progress
//   o_dout_vld     : o_rd_en delayed one cycle (aligned with RAM data)
//   o_last         : with the read of the final symbol
//   o_done         : one cycle after the final read
//   o_busy         : controller not idle
//   o_err          : reserved size or queue overflow, one cycle after i_start
module turbo_rd_len
    import turbo_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_n_rst,
    input  logic             i_start,
    input  logic [1:0]       i_pb_size,
    input  logic             i_rd_rdy,
    output logic             o_rd_en,
    output logic [LEN_W-1:0] o_rd_addr,
    output logic             o_rd_bank,
    output logic [LEN_W-1:0] o_pb_len,
    output logic             o_dout_vld,
    output logic             o_last,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_err
);

    state_e           r_state, w_next;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cur_len;   // L of the accepted size, waiting for LOAD
    logic [LEN_W-1:0] r_pend_len;  // L of the queued request
    logic             r_pend;
    logic             r_bank;
    logic             r_vld;
    logic             r_err;

    logic [LEN_W-1:0] w_in_len;
    logic             w_in_vld;
    logic             w_start_ok;
    logic             w_rd_en;
    logic             w_last;
    logic             w_err;

    // Sizes are stored in decoded form; LOAD only has to copy into pb_len.
    pb_len_dec u_dec (
        .i_size (i_pb_size),
        .o_len  (w_in_len),
        .o_vld  (w_in_vld)
    );

    assign w_start_ok = i_start & w_in_vld;
    assign w_rd_en    = (r_state == ST_READ) & i_rd_rdy;
    assign w_last     = w_rd_en & (r_cnt == (r_len - 12'd1));

    // Outside IDLE a start goes to the single-entry queue; a second one
    // while the queue is full is dropped and flagged.
    assign w_err = i_start & (~w_in_vld | ((r_state != ST_IDLE) & r_pend));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_ok) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_READ;
            ST_READ: if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = (r_pend | w_start_ok) ? ST_LOAD : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_cur_len <= '0;
            r_bank    <= 1'b0;
            r_vld     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_vld   <= w_rd_en;
            r_err   <= w_err;
            case (r_state)
                ST_IDLE: if (w_start_ok) r_cur_len <= w_in_len;
                ST_LOAD: begin
                    r_len <= r_cur_len;
                    r_cnt <= '0;
                end
                ST_READ: if (w_rd_en) r_cnt <= r_cnt + 12'd1;
                ST_DONE: begin
                    r_bank <= ~r_bank;
                    // A queued request wins; an empty queue lets a start
                    // arriving right now go straight to LOAD.
                    if (r_pend)          r_cur_len <= r_pend_len;
                    else if (w_start_ok) r_cur_len <= w_in_len;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_pend     <= 1'b0;
            r_pend_len <= '0;
        end else if ((r_state == ST_DONE) && r_pend) begin
            r_pend <= 1'b0;
        end else if (((r_state == ST_LOAD) || (r_state == ST_READ)) &&
                     w_start_ok && !r_pend) begin
            r_pend     <= 1'b1;
            r_pend_len <= w_in_len;
        end
    end

    assign o_rd_en    = w_rd_en;
    assign o_rd_addr  = r_cnt;
    assign o_rd_bank  = r_bank;
    assign o_pb_len   = r_len;
    assign o_dout_vld = r_vld;
    assign o_last     = w_last;
    assign o_done     = (r_state == ST_DONE);
    assign o_busy     = (r_state != ST_IDLE);
    assign o_err      = r_err;

endmodule
